// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] PC_R15_OFS = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC adder: sequential pc+4, or branch target pc+8+imm, always word aligned.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_imm,
  output logic [31:0] next_pc
);

  logic [31:0] sum;

  always_comb begin
    sum     = br_taken ? (pc + PC_R15_OFS + br_imm) : (pc + PC_INC);
    next_pc = word_align(sum);
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with branch redirect.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// REQ   | issue imem_req for pc this cycle
// WAIT  | waiting for imem_valid, capture imem_rdata into instr
// HOLD  | instr_valid high, instr/pc_out held until accepted
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  input  logic        br_taken,
  input  logic [31:0] br_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         accept;

  fetch_pc_next u_pc_next (
    .pc       (pc),
    .br_taken (br_taken),
    .br_imm   (br_imm),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= REQ;
      pc    <= word_align(RESET_PC);
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && imem_valid) instr <= imem_rdata;
      if (accept) pc <= next_pc;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      REQ: begin
        imem_req  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_valid) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        accept      = instr_ready;
        if (instr_ready) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  assign imem_addr = word_align(pc);
  assign pc_out    = pc;
  assign pc_plus8  = pc + PC_R15_OFS;

`ifdef FETCH_PERF_CNT_EN
  // Stall counts only WAIT cycles that did not receive the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == WAIT && !imem_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: imem_req  output  1  instruction memory read request, one-cycle pulse.
REQ-005 The block SHALL have port: imem_addr  output  32  fetch address; bits [1:0] always 2'b00.
REQ-006 The block SHALL have port: imem_valid  input  1  read response valid; latency >= 1 cycle after imem_req.
REQ-007 The block SHALL have port: imem_rdata  input  32  read response data.
REQ-008 The block SHALL have port: instr_valid  output  1  instr holds a fetched instruction for decode.
REQ-009 The block SHALL have port: instr  output  32  held instruction; Instr[23:0] drives immediate extension.
REQ-010 The block SHALL have port: instr_ready  input  1  decode/execute accepts instr this cycle.
REQ-011 The block SHALL have port: pc_out  output  32  address of held instruction.
REQ-012 The block SHALL have port: pc_plus8  output  32  pc_out + 8, the R15 read value.
REQ-013 The block SHALL have port: br_taken  input  1  held instruction is a taken branch (condition passed).
REQ-014 The block SHALL have port: br_imm  input  32  extended immediate: sign-extended imm24, already shifted left 2.

Function
REQ-015 The FSM SHALL have exactly three states: REQ, WAIT, HOLD.
REQ-016 In REQ the block SHALL assert imem_req=1 with imem_addr=pc and go to WAIT next cycle; imem_req SHALL be 0 in all other states.
REQ-017 In WAIT, on imem_valid=1, the block SHALL capture imem_rdata into instr and go to HOLD; otherwise it stays in WAIT.
REQ-018 In HOLD, instr_valid SHALL be 1, and instr/pc_out SHALL be stable until accept (instr_valid && instr_ready).
REQ-019 On accept, pc SHALL update to pc+8+br_imm if br_taken=1, else pc+4, and the FSM SHALL return to REQ.
REQ-020 Arithmetic SHALL be 32-bit modulo 2^32 (wrap at 32'hFFFF_FFFC -> 0); target bits [1:0] SHALL be forced to 00.
REQ-021 imem_valid outside WAIT SHALL be ignored; br_taken/br_imm SHALL be ignored unless accept occurs.
REQ-022 At most one memory request SHALL be outstanding; best-case throughput is one instruction per 3 cycles.
REQ-023 instr_ready may be high before instr_valid; no accept SHALL occur without instr_valid.

Reset
REQ-024 On reset assertion, regardless of state, the block SHALL immediately set state=REQ, pc=RESET_PC, instr=0, instr_valid=0, and perf counters to 0.
REQ-025 The first imem_req SHALL occur in the first clk cycle after reset deasserts; a response pending at reset SHALL be discarded (it arrives in REQ and is ignored).

Configuration
REQ-026 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs perf_fetch_cnt[31:0] (+1 per accept) and perf_stall_cnt[31:0] (+1 per WAIT cycle with imem_valid=0), both wrapping modulo 2^32.
REQ-027 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-028 The package fetch_pkg SHALL hold the FSM state enum (REQ/WAIT/HOLD), PC_INC=4, and PC_R15_OFS=8.
REQ-029 The sub-module fetch_pc_next SHALL hold the combinational next-PC/target adder (pc, br_taken, br_imm -> next_pc); all state lives in fetch_unit.

Verification
REQ-030 The bench SHALL cover: reset release, memory latency 1, instr_ready=1 -> imem_addr 0,4,8 on cycles 1,4,7; instr_valid on cycles 3,6.
REQ-031 The bench SHALL cover: pc_out=0x100, br_taken=1, br_imm=0xFFFF_FFF8 accepted -> next imem_addr=0x100.
REQ-032 The bench SHALL cover: instr_ready=0 for 5 cycles in HOLD -> instr, pc_out, pc_plus8 unchanged; no imem_req issued.
REQ-033 The bench SHALL cover: memory latency 4 with FETCH_PERF_CNT_EN -> perf_stall_cnt +3 per fetch; perf_fetch_cnt +1 per accept.
REQ-034 The bench SHALL cover: reset asserted mid-WAIT, then late imem_valid -> ignored; instr_valid=0; next imem_addr=RESET_PC.
REQ-035 The bench SHALL cover: pc=0xFFFF_FFFC accepted, not taken -> next imem_addr=0x0000_0000.
